reorder_buffer: RTL
===================

// Module: reorder_buffer
// PURPOSE
//  Circular reorder buffer that allocates tags to issued instructions and gathers results from the ALU and LSB.
//  Retires one instruction per cycle, in order.
//  Drives the regfile commit interface and answers operand lookups by ROB id.
//  Raises clear and redirect_pc when a committed branch was mispredicted.
// PARAMETERS
//  DEPTH  (1<<`ROB_WIDTH)  number of entries; `ROB_WIDTH comes from the shared defines
// PORTS
//  clk_in           in   1   system clock
//  rst_n_in         in   1   asynchronous reset, active low
//  rdy_in           in   1   low = freeze all state and hold outputs
//  issue_valid      in   1   decoder issues one instruction
//  issue_type       in   2   ROB_T_REG / ROB_T_BR / ROB_T_ST
//  issue_rd         in   5   destination register (0 = none)
//  issue_pc         in   32  instruction PC
//  issue_pred_taken in   1   predictor decision (BR only)
//  issue_ready_now  in   1   result already known at issue (LUI/AUIPC/JAL)
//  issue_val        in   32  result when issue_ready_now = 1
//  issue_rob_id     out  `ROB_WIDTH  tag given to the issuing instruction (= tail)
//  rob_full         out  1   count == DEPTH
//  rob_empty        out  1   count == 0
//  alu_wb_valid/alu_wb_rob_id/alu_wb_val  in 1/`ROB_WIDTH/32  ALU writeback
//  alu_wb_taken/alu_wb_target             in 1/32             branch outcome
//  lsb_wb_valid/lsb_wb_rob_id/lsb_wb_val  in 1/`ROB_WIDTH/32  load/store done
//  search_rob_id_1/2 in  `ROB_WIDTH  operand tags from the regfile
//  search_ready_1/2 out  1   tagged entry holds its result
//  search_val_1/2   out  32  that result
//  commit_ready     out  1   one-cycle commit pulse
//  commit_reg_id    out  5   destination; forced to 0 when not committing
//  commit_val       out  32  committed value
//  commit_rob_id    out  `ROB_WIDTH  committed tag
//  commit_store     out  1   pulse: LSB may perform the store tagged commit_rob_id
//  clear            out  1   one-cycle flush pulse to all units
//  redirect_pc      out  32  fetch target, valid while clear = 1
// BEHAVIOUR
//  Reset: head, tail, count = 0; every busy/ready bit = 0; all outputs = 0.
//  Issue
//   - Accepted at an edge when issue_valid && !rob_full && !clear.
//   - Entry[tail] gets busy = 1, ready = issue_ready_now, and the issue fields; tail++ mod DEPTH.
//   - An issue while rob_full is ignored. rob_full uses the registered count, so a commit on the same edge frees no slot that cycle.
//  Writeback
//   - Each valid port sets ready and val on a busy entry. ALU also stores taken and target.
//   - Both ports may be valid on the same edge; their ids are always distinct.
//  Commit
//   - At an edge where entry[head] is busy and ready: commit registers load, the entry is freed, head++.
//   - Outputs are visible for exactly one cycle.
//   - commit_reg_id = rd for REG and 0 for BR/ST. commit_store = 1 for ST only.
//   - Latency: a writeback sampled at edge E gives commit_ready high after edge E+1 if the entry is at head.
//  Count: +1 on issue, -1 on commit, unchanged when both occur.
//  Mispredict (BR commit with taken != pred_taken)
//   - At the same edge: clear <= 1; redirect_pc <= taken ? target : pc+4; head = tail = count = 0; all busy bits cleared.
//   - A same-edge issue is discarded.
//   - While clear = 1, issue and writeback are ignored and no commit occurs. clear drops at the next edge.
//  Search is combinational: ready = busy && ready[id]; val = val[id] when ready, else 0.
//  Wrap-around: pointers roll DEPTH-1 -> 0. Full and empty are distinguished by count.
//  rdy_in low: no state changes; outputs hold.
//  Reset asserted mid-operation: immediate return to reset values.
// CONFIGURATION
//  ROB_SEARCH_FWD_EN
//   - Defined: search ports also match the current-cycle alu/lsb writeback and return that value with ready = 1 (LSB port has priority over stored data).
//   - Undefined: search ports see stored entries only.
// STRUCTURE
//  Shared header rob_defines.vh: `ROB_WIDTH and localparams ROB_T_REG = 2'd0, ROB_T_BR = 2'd1, ROB_T_ST = 2'd2.
//  Sub-module rob_search_port, instantiated twice: tag lookup plus optional forward mux.
// TESTING
//  1. Issue REG rd=5 and get id 0. ALU wb id 0, val 0x1234 at edge E.
//     -> After E+1: commit_ready=1, commit_reg_id=5, commit_val=0x1234, commit_rob_id=0 for one cycle.
//  2. Issue DEPTH instructions, none ready.
//     -> rob_full=1; a further issue is ignored and tail does not change.
//     Then commit all of them.
//     -> tail wraps to 0; rob_empty=1.
//  3. BR pc=0x100, pred=0, wb taken=1 target=0x200, followed by 3 younger entries.
//     -> Branch commit with reg_id 0, then clear=1, redirect_pc=0x200 for one cycle.
//     -> count=0; younger entries never commit.
//  4. Writebacks out of order: ids 2, 1, then 0.
//     -> Commits occur in order 0, 1, 2 on consecutive cycles.
//  5. ROB_SEARCH_FWD_EN defined: search id 3 while alu_wb id 3 val 7 is in flight.
//     -> Same cycle: search_ready=1, search_val=7.
//     Without the macro: ready=0 that cycle, ready=1 the next.
//  6. Drop rdy_in while commit_ready=1 -> outputs hold. Pulse rst_n_in low mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// ============================================================================
// Module  : reorder_buffer_pkg
// Brief   : Shared ROB width, depth, entry type codes and entry record.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ROB_WIDTH
`define ROB_WIDTH 3
`endif

package reorder_buffer_pkg;

    localparam int ROB_W = `ROB_WIDTH;
    localparam int DEPTH = 1 << `ROB_WIDTH;

    typedef enum logic [1:0] {
        ROB_T_REG = 2'd0,
        ROB_T_BR  = 2'd1,
        ROB_T_ST  = 2'd2
    } rob_type_e;

    typedef struct packed {
        logic        ready;
        rob_type_e   typ;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        pred;
        logic [31:0] val;
        logic        taken;
        logic [31:0] target;
    } rob_entry_t;

    function automatic logic [31:0] redirect_target(input rob_entry_t e);
        return e.taken ? e.target : e.pc + 32'd4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reorder_buffer_if.sv
// ============================================================================
// Module  : reorder_buffer_if
// Brief   : Issue, writeback, operand search and commit bus of the ROB.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic             issue_valid;
    logic [1:0]       issue_type;
    logic [4:0]       issue_rd;
    logic [31:0]      issue_pc;
    logic             issue_pred_taken;
    logic             issue_ready_now;
    logic [31:0]      issue_val;
    logic [ROB_W-1:0] issue_rob_id;
    logic             rob_full;
    logic             rob_empty;

    logic             alu_wb_valid;
    logic [ROB_W-1:0] alu_wb_rob_id;
    logic [31:0]      alu_wb_val;
    logic             alu_wb_taken;
    logic [31:0]      alu_wb_target;
    logic             lsb_wb_valid;
    logic [ROB_W-1:0] lsb_wb_rob_id;
    logic [31:0]      lsb_wb_val;

    logic [ROB_W-1:0] search_rob_id_1;
    logic [ROB_W-1:0] search_rob_id_2;
    logic             search_ready_1;
    logic             search_ready_2;
    logic [31:0]      search_val_1;
    logic [31:0]      search_val_2;

    logic             commit_ready;
    logic [4:0]       commit_reg_id;
    logic [31:0]      commit_val;
    logic [ROB_W-1:0] commit_rob_id;
    logic             commit_store;
    logic             clear;
    logic [31:0]      redirect_pc;

    modport master (
        output issue_valid, issue_type, issue_rd, issue_pc, issue_pred_taken,
               issue_ready_now, issue_val,
               alu_wb_valid, alu_wb_rob_id, alu_wb_val, alu_wb_taken, alu_wb_target,
               lsb_wb_valid, lsb_wb_rob_id, lsb_wb_val,
               search_rob_id_1, search_rob_id_2,
        input  issue_rob_id, rob_full, rob_empty,
               search_ready_1, search_ready_2, search_val_1, search_val_2,
               commit_ready, commit_reg_id, commit_val, commit_rob_id, commit_store,
               clear, redirect_pc
    );

    modport slave (
        input  issue_valid, issue_type, issue_rd, issue_pc, issue_pred_taken,
               issue_ready_now, issue_val,
               alu_wb_valid, alu_wb_rob_id, alu_wb_val, alu_wb_taken, alu_wb_target,
               lsb_wb_valid, lsb_wb_rob_id, lsb_wb_val,
               search_rob_id_1, search_rob_id_2,
        output issue_rob_id, rob_full, rob_empty,
               search_ready_1, search_ready_2, search_val_1, search_val_2,
               commit_ready, commit_reg_id, commit_val, commit_rob_id, commit_store,
               clear, redirect_pc
    );

endinterface

`default_nettype wire

// File: rtl/reorder_buffer_search_port.sv
// ============================================================================
// Module  : rob_search_port
// Brief   : Operand lookup by ROB id; ROB_SEARCH_FWD_EN adds writeback bypass.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_search_port
    import reorder_buffer_pkg::*;
(
    input  logic [ROB_W-1:0]       search_id_i,
    input  logic [DEPTH-1:0]       busy_i,
    input  logic [DEPTH-1:0]       ready_i,
    input  logic [DEPTH-1:0][31:0] val_i,
    input  logic                   alu_wb_valid_i,
    input  logic [ROB_W-1:0]       alu_wb_id_i,
    input  logic [31:0]            alu_wb_val_i,
    input  logic                   lsb_wb_valid_i,
    input  logic [ROB_W-1:0]       lsb_wb_id_i,
    input  logic [31:0]            lsb_wb_val_i,
    output logic                   ready_o,
    output logic [31:0]            val_o
);

    logic w_hit;
    assign w_hit = busy_i[search_id_i] && ready_i[search_id_i];

`ifdef ROB_SEARCH_FWD_EN
    // Writeback valids arrive pre-qualified; LSB is evaluated last so it wins.
    always_comb begin
        ready_o = w_hit;
        val_o   = w_hit ? val_i[search_id_i] : 32'd0;
        if (alu_wb_valid_i && (alu_wb_id_i == search_id_i)) begin
            ready_o = 1'b1;
            val_o   = alu_wb_val_i;
        end
        if (lsb_wb_valid_i && (lsb_wb_id_i == search_id_i)) begin
            ready_o = 1'b1;
            val_o   = lsb_wb_val_i;
        end
    end
`else
    assign ready_o = w_hit;
    assign val_o   = w_hit ? val_i[search_id_i] : 32'd0;

    logic w_unused_fwd;
    assign w_unused_fwd = ^{alu_wb_valid_i, alu_wb_id_i, alu_wb_val_i,
                            lsb_wb_valid_i, lsb_wb_id_i, lsb_wb_val_i};
`endif

endmodule

`default_nettype wire

// File: rtl/reorder_buffer.sv
// ============================================================================
// Module  : reorder_buffer
// Brief   : In-order retiring circular ROB with mispredict flush.
//           Optional macro ROB_SEARCH_FWD_EN enables search bypass.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            rdy_in,
    reorder_buffer_if.slave bus
);

    localparam logic [ROB_W:0] c_depth = (ROB_W+1)'(DEPTH);

    logic [ROB_W-1:0] head_q, head_d;
    logic [ROB_W-1:0] tail_q, tail_d;
    logic [ROB_W:0]   count_q, count_d;
    logic [DEPTH-1:0] busy_q;
    rob_entry_t       ent_q [DEPTH];

    logic             commit_ready_q;
    logic [4:0]       commit_reg_id_q;
    logic [31:0]      commit_val_q;
    logic [ROB_W-1:0] commit_rob_id_q;
    logic             commit_store_q;
    logic             clear_q;
    logic [31:0]      redirect_pc_q;

    rob_entry_t             w_head;
    logic                   w_full;
    logic                   w_commit;
    logic                   w_mispredict;
    logic                   w_issue;
    logic                   w_alu_wr;
    logic                   w_lsb_wr;
    logic [DEPTH-1:0]       w_ready;
    logic [DEPTH-1:0][31:0] w_val;

    assign w_head       = ent_q[head_q];
    assign w_full       = (count_q == c_depth);
    assign w_commit     = !clear_q && busy_q[head_q] && w_head.ready;
    assign w_mispredict = w_commit && (w_head.typ == ROB_T_BR) && (w_head.taken != w_head.pred);
    assign w_issue      = bus.issue_valid && !w_full && !clear_q && !w_mispredict;
    assign w_alu_wr     = !clear_q && bus.alu_wb_valid && busy_q[bus.alu_wb_rob_id];
    assign w_lsb_wr     = !clear_q && bus.lsb_wb_valid && busy_q[bus.lsb_wb_rob_id];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (w_mispredict) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (w_commit) head_d = head_q + ROB_W'(1);
            if (w_issue)  tail_d = tail_q + ROB_W'(1);
            if (w_issue && !w_commit)      count_d = count_q + (ROB_W+1)'(1);
            else if (!w_issue && w_commit) count_d = count_q - (ROB_W+1)'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            busy_q          <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            commit_ready_q  <= 1'b0;
            commit_reg_id_q <= '0;
            commit_val_q    <= '0;
            commit_rob_id_q <= '0;
            commit_store_q  <= 1'b0;
            clear_q         <= 1'b0;
            redirect_pc_q   <= '0;
        end else if (rdy_in) begin
            if (clear_q) begin
                // Flush cycle: only the pulses fall, everything else waits.
                clear_q         <= 1'b0;
                commit_ready_q  <= 1'b0;
                commit_store_q  <= 1'b0;
                commit_reg_id_q <= '0;
            end else begin
                head_q          <= head_d;
                tail_q          <= tail_d;
                count_q         <= count_d;
                commit_ready_q  <= w_commit;
                commit_store_q  <= w_commit && (w_head.typ == ROB_T_ST);
                commit_reg_id_q <= (w_commit && (w_head.typ == ROB_T_REG)) ? w_head.rd : 5'd0;
                if (w_commit) begin
                    commit_val_q    <= w_head.val;
                    commit_rob_id_q <= head_q;
                    busy_q[head_q]  <= 1'b0;
                end
                if (w_alu_wr) begin
                    ent_q[bus.alu_wb_rob_id].ready  <= 1'b1;
                    ent_q[bus.alu_wb_rob_id].val    <= bus.alu_wb_val;
                    ent_q[bus.alu_wb_rob_id].taken  <= bus.alu_wb_taken;
                    ent_q[bus.alu_wb_rob_id].target <= bus.alu_wb_target;
                end
                if (w_lsb_wr) begin
                    ent_q[bus.lsb_wb_rob_id].ready <= 1'b1;
                    ent_q[bus.lsb_wb_rob_id].val   <= bus.lsb_wb_val;
                end
                if (w_issue) begin
                    busy_q[tail_q] <= 1'b1;
                    ent_q[tail_q]  <= '{ready:  bus.issue_ready_now,
                                        typ:    rob_type_e'(bus.issue_type),
                                        rd:     bus.issue_rd,
                                        pc:     bus.issue_pc,
                                        pred:   bus.issue_pred_taken,
                                        val:    bus.issue_val,
                                        taken:  1'b0,
                                        target: 32'd0};
                end
                if (w_mispredict) begin
                    clear_q       <= 1'b1;
                    redirect_pc_q <= redirect_target(w_head);
                    busy_q        <= '0;
                end
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_flat
        assign w_ready[i] = ent_q[i].ready;
        assign w_val[i]   = ent_q[i].val;
    end

    rob_search_port u_search_1 (
        .search_id_i    (bus.search_rob_id_1),
        .busy_i         (busy_q),
        .ready_i        (w_ready),
        .val_i          (w_val),
        .alu_wb_valid_i (w_alu_wr),
        .alu_wb_id_i    (bus.alu_wb_rob_id),
        .alu_wb_val_i   (bus.alu_wb_val),
        .lsb_wb_valid_i (w_lsb_wr),
        .lsb_wb_id_i    (bus.lsb_wb_rob_id),
        .lsb_wb_val_i   (bus.lsb_wb_val),
        .ready_o        (bus.search_ready_1),
        .val_o          (bus.search_val_1)
    );

    rob_search_port u_search_2 (
        .search_id_i    (bus.search_rob_id_2),
        .busy_i         (busy_q),
        .ready_i        (w_ready),
        .val_i          (w_val),
        .alu_wb_valid_i (w_alu_wr),
        .alu_wb_id_i    (bus.alu_wb_rob_id),
        .alu_wb_val_i   (bus.alu_wb_val),
        .lsb_wb_valid_i (w_lsb_wr),
        .lsb_wb_id_i    (bus.lsb_wb_rob_id),
        .lsb_wb_val_i   (bus.lsb_wb_val),
        .ready_o        (bus.search_ready_2),
        .val_o          (bus.search_val_2)
    );

    assign bus.issue_rob_id  = tail_q;
    assign bus.rob_full      = w_full;
    assign bus.rob_empty     = (count_q == '0);
    assign bus.commit_ready  = commit_ready_q;
    assign bus.commit_reg_id = commit_reg_id_q;
    assign bus.commit_val    = commit_val_q;
    assign bus.commit_rob_id = commit_rob_id_q;
    assign bus.commit_store  = commit_store_q;
    assign bus.clear         = clear_q;
    assign bus.redirect_pc   = redirect_pc_q;

endmodule

`default_nettype wire
